// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory serving MEM-stage loads/stores; DMEM_ALIGN_CHECK_EN enables error checks.
// Stores respond 1 cycle after acceptance, loads after LAT cycles; req_ready drops while a load waits.
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic        rsp_valid,
  output logic [63:0] read_data,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  mem [DEPTH_BYTES];

  logic          size_ok;
  logic [3:0]    eff_size;
  logic [AW-1:0] base_idx;
  logic [7:0]    byte_en;
  logic          err_req;
  logic          is_store;
  logic          is_load;
  logic          accept;
  logic          store_commit;
  logic [63:0]   load_word;

  assign size_ok  = (xfer_size == 4'd1) || (xfer_size == 4'd2) ||
                    (xfer_size == 4'd4) || (xfer_size == 4'd8);
  assign eff_size = size_ok ? xfer_size : 4'd8;
  // Forcing alignment here is a no-op for requests that pass the checks.
  assign base_idx = address[AW-1:0] & ~(AW'(eff_size - 4'd1));

  always_comb begin
    byte_en = 8'hFF;
    case (eff_size)
      4'd1:    byte_en = 8'h01;
      4'd2:    byte_en = 8'h03;
      4'd4:    byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  logic out_of_range;

  assign misaligned   = |(address[3:0] & (xfer_size - 4'd1));
  assign out_of_range = ({1'b0, address} + {61'd0, xfer_size}) > 65'(DEPTH_BYTES);
  assign err_req      = (write_enable && read_enable) || !size_ok || misaligned || out_of_range;
  assign is_store     = write_enable && !read_enable && !err_req;
  assign is_load      = read_enable && !write_enable && !err_req;
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^address[63:AW];
  assign err_req        = 1'b0;
  assign is_store       = write_enable;
  assign is_load        = read_enable && !write_enable;
`endif

  assign req_ready    = (state_q != S_WAIT);
  assign accept       = req_valid && req_ready;
  // A store seen on an edge where reset is high must not reach the array.
  assign store_commit = accept && is_store && !reset;

  always_comb begin
    load_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) load_word[8*i +: 8] = mem[base_idx + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (store_commit) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en[i]) mem[base_idx + AW'(i)] <= write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase
    if (accept) begin
      if (is_load) begin
        rdata_d = load_word;
        err_d   = 1'b0;
        if (LAT > 1) begin
          state_d = S_WAIT;
          cnt_d   = 3'(LAT - 1);
        end else begin
          state_d = S_RESP;
        end
      end else if (is_store || err_req) begin
        rdata_d = '0;
        err_d   = err_req;
        state_d = S_RESP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign read_data = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [63:0] write_data;
  logic [3:0]  xfer_size;
  logic        rsp_valid;
  logic [63:0] read_data;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [DEPTH];
  logic [63:0] last_rd;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .write_enable(write_enable), .read_enable(read_enable),
    .write_data(write_data), .xfer_size(xfer_size), .rsp_valid(rsp_valid),
    .read_data(read_data), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit legal_size(input logic [3:0] s);
    return (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
  endfunction

  function automatic longint unsigned model_base(input logic [63:0] a, input int e);
    return a - (a % e);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input int e);
    logic [63:0] r = '0;
    longint unsigned b = model_base(a, e);
    for (int i = 0; i < e; i++) r[8*i +: 8] = ref_mem[(b + i) % DEPTH];
    return r;
  endfunction

  task automatic drive(input logic we, input logic re, input logic [63:0] a,
                       input logic [3:0] sz, input logic [63:0] wd);
    write_enable = we;
    read_enable  = re;
    address      = a;
    xfer_size    = sz;
    write_data   = wd;
    req_valid    = 1'b1;
  endtask

  // One complete transaction from an idle DUT, checked against the model.
  task automatic do_op(input logic we, input logic re, input logic [63:0] a,
                       input logic [3:0] sz, input logic [63:0] wd);
    bit is_err = 0;
    bit is_store, is_load, is_noop;
    int e = legal_size(sz) ? int'(sz) : 8;
    int exp_lat, k;
    logic [63:0] exp_rd;
`ifdef DMEM_ALIGN_CHECK_EN
    if (we && re) is_err = 1;
    else if (!legal_size(sz)) is_err = 1;
    else if ((a % sz) != 0) is_err = 1;
    else if (({1'b0, a} + sz) > DEPTH) is_err = 1;
`endif
    is_store = we && !is_err;
    is_load  = re && !we && !is_err;
    is_noop  = !we && !re;
    exp_lat  = is_load ? LAT : 1;
    exp_rd   = is_load ? model_load(a, e) : 64'd0;
    if (is_store) begin
      longint unsigned b = model_base(a, e);
      for (int i = 0; i < e; i++) ref_mem[(b + i) % DEPTH] = wd[8*i +: 8];
    end

    @(negedge clk);
    drive(we, re, a, sz, wd);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (is_noop) begin
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL noop_rsp: rsp_valid=%b expected 0", rsp_valid);
      if (rsp_valid !== 1'b0) errors++;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL noop_rsp_late: rsp_valid=%b expected 0", rsp_valid);
      end
      return;
    end
    k = 1;
    while (rsp_valid !== 1'b1 && k < LAT + 3) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || k != exp_lat) begin
      errors++;
      $display("FAIL latency: rsp at cycle %0d (rsp_valid=%b) expected cycle %0d addr=%h we=%b re=%b",
               k, rsp_valid, exp_lat, a, we, re);
    end
    checks++;
    if (read_data !== exp_rd) begin
      errors++;
      $display("FAIL read_data: got %h expected %h addr=%h size=%0d we=%b re=%b",
               read_data, exp_rd, a, sz, we, re);
    end
    checks++;
    if (err !== is_err) begin
      errors++;
      $display("FAIL err: got %b expected %b addr=%h size=%0d", err, is_err, a, sz);
    end
    last_rd = read_data;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_pulse: rsp_valid=%b expected 0 one cycle after response", rsp_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 4'd8, 64'd0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 0", rsp_valid); end
    checks++;
    if (read_data !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", read_data); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_fill;
    for (int a = 0; a < DEPTH; a += 8)
      do_op(1'b1, 1'b0, 64'(a), 4'd8, {$urandom, $urandom});
  endtask

  task automatic test_plan;
    do_op(1'b1, 1'b0, 64'h10, 4'd8, 64'h1122334455667788);
    do_op(1'b0, 1'b1, 64'h10, 4'd8, 64'd0);
    checks++;
    if (last_rd !== 64'h1122334455667788) begin
      errors++; $display("FAIL plan_load8: got %h expected 1122334455667788", last_rd);
    end
    do_op(1'b1, 1'b0, 64'h13, 4'd1, 64'hFFFF_FFFF_FFFF_FFAB);
    do_op(1'b0, 1'b1, 64'h10, 4'd4, 64'd0);
    checks++;
    if (last_rd !== 64'h00000000AB667788) begin
      errors++; $display("FAIL plan_load4: got %h expected 00000000ab667788", last_rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d = {$urandom, $urandom};
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h40, 4'd8, d);
    for (int i = 0; i < 8; i++) ref_mem[64 + i] = d[8*i +: 8];
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_store_rsp: got %b expected 1", rsp_valid); end
    drive(1'b0, 1'b1, 64'h40, 4'd8, 64'd0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL wait_ready: got %b expected 0", req_ready); end
    drive(1'b1, 1'b0, 64'h80, 4'd8, ~d);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || read_data !== d) begin
      errors++; $display("FAIL b2b_load: rsp_valid=%b data=%h expected 1/%h", rsp_valid, read_data, d);
    end
    @(negedge clk);
    do_op(1'b0, 1'b1, 64'h80, 4'd8, 64'd0);
  endtask

  task automatic test_align;
    do_op(1'b0, 1'b1, 64'h11, 4'd4, 64'd0);
    do_op(1'b1, 1'b0, 64'h3FC, 4'd8, 64'hDEAD_BEEF_CAFE_F00D);
    do_op(1'b0, 1'b1, 64'h3F8, 4'd8, 64'd0);
    do_op(1'b1, 1'b1, 64'h20, 4'd4, 64'h0BAD_F00D);
    do_op(1'b0, 1'b1, 64'h20, 4'd4, 64'd0);
    do_op(1'b0, 1'b1, 64'h30, 4'd3, 64'd0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      int kind = $urandom_range(0, 9);
      logic [3:0]  sz;
      logic [63:0] a;
      case ($urandom_range(0, 4))
        0: sz = 4'd1;
        1: sz = 4'd2;
        2: sz = 4'd4;
        3: sz = 4'd8;
        default: sz = 4'($urandom_range(0, 15));
      endcase
      a = 64'($urandom_range(0, DEPTH + 15));
      if ($urandom_range(0, 1) == 1 && legal_size(sz)) a = a & ~64'(sz - 4'd1);
      if ($urandom_range(0, 19) == 0) a = {$urandom, $urandom};
      if (kind < 4)       do_op(1'b1, 1'b0, a, sz, {$urandom, $urandom});
      else if (kind < 8)  do_op(1'b0, 1'b1, a, sz, 64'd0);
      else if (kind == 8) do_op(1'b1, 1'b1, a, sz, {$urandom, $urandom});
      else                do_op(1'b0, 1'b0, a, sz, {$urandom, $urandom});
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h18, 4'd8, 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_wait_ready: got %b expected 0", req_ready); end
    reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || read_data !== 64'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rsp=%b rdy=%b data=%h err=%b expected 0/1/0/0",
               rsp_valid, req_ready, read_data, err);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_rsp: got %b expected 0", rsp_valid); end
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", req_ready); end
    // A store presented while reset is high must leave the array untouched.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 64'h28, 4'd8, 64'h5A5A_5A5A_5A5A_5A5A);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    do_op(1'b0, 1'b1, 64'h28, 4'd8, 64'd0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_plan();
    test_back_to_back();
    test_align();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the pipeline's data-memory request interface. The MEM stage issues load and store requests over a valid/ready handshake; this block serves them from a byte-addressed, little-endian array. Stores commit in one cycle. Loads return after a configurable latency. The pipeline holds MEM until `rsp_valid`, so this block also functions as a memory-stall source.

## Interface

Parameters:
- `DEPTH_BYTES`, 1024: array size in bytes. Power of two, ≥ 8.
- `LAT`, 2: load latency in cycles, legal range 1..4.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `address`  in  64  byte address.
- `write_enable`  in  1  store request.
- `read_enable`  in  1  load request.
- `write_data`  in  64  store data; low `xfer_size` bytes are used.
- `xfer_size`  in  4  bytes to transfer; legal values 1, 2, 4, 8.
- `rsp_valid`  out  1  one-cycle response strobe.
- `read_data`  out  64  load result, zero-extended; 0 for store and error responses.
- `err`  out  1  error flag, qualified by `rsp_valid`.

## Operation

- A request is accepted on a rising edge where `req_valid && req_ready`. Request inputs are sampled only on that edge.
- Each request is classified at acceptance:
  - **Store:** `write_enable=1`, `read_enable=0`.
  - **Load:** `read_enable=1`, `write_enable=0`.
  - **Both set:** error.
  - **Neither set:** no-op. It is accepted, state does not change, and no response is produced.
- Error conditions, when `DMEM_ALIGN_CHECK_EN` is defined: illegal `xfer_size`, `address % xfer_size != 0`, or `address + xfer_size > DEPTH_BYTES`. An error performs no array write and produces a response with `err=1`.
- Store: bytes `address .. address+xfer_size-1` ← `write_data[8*xfer_size-1:0]`, with byte 0 at `address`. All other bytes are unchanged.
- Load: bytes are captured into `read_data` with byte 0 at `address` placed in `read_data[7:0]`. Upper bytes are 0.
- State machine:
  - **IDLE:** `req_ready=1`.
    - Accept load with `LAT>1` → WAIT, counter loaded with `LAT-1`.
    - Accept load with `LAT=1`, store, or error → RESP.
    - Accept no-op → stays IDLE.
  - **WAIT:** `req_ready=0`. Counter decrements each cycle. At 1 → RESP.
  - **RESP:** `rsp_valid=1`, `req_ready=1`. A new request may be accepted on the edge that exits RESP; the transition follows the IDLE rules. With no acceptance → IDLE.
- Load data is read from the array when the load is accepted. It is held in a capture register through WAIT, so a later store cannot alter it. No store can be accepted during WAIT in any case.
- Array contents are not reset.

## Timing

- Reset values: `req_ready=1`, `rsp_valid=0`, `read_data=0`, `err=0`; state=IDLE; counter=0.
- Load accepted at edge N: `rsp_valid` is high for exactly the cycle after edge N+LAT-1, i.e. it is first visible after edge N+LAT-1 and drops at edge N+LAT unless a load/store/error is accepted at that edge.
- Store or error accepted at edge N: the array updates at edge N, and `rsp_valid` is high for the cycle following edge N. Store and error responses therefore have 1-cycle latency.
- Back-to-back: a store accepted at edge N followed by a load of the same address accepted at edge N+1 returns the new data.
- Throughput: one store per cycle; one load per `LAT` cycles.
- Reset asserted mid-operation: a pending load is discarded, and no `rsp_valid` is produced for it after reset releases. A store accepted on the same edge reset is asserted is not committed.
- `read_data` and `err` hold their values outside `rsp_valid` and must be ignored there.

## Configuration

- `DMEM_ALIGN_CHECK_EN` defined: the error checks above apply, and `err` is driven.
- Not defined:
  - `err` is tied to 0.
  - `address` is forced aligned: `address & ~(xfer_size-1)`.
  - The index wraps modulo `DEPTH_BYTES`.
  - An illegal `xfer_size` is treated as 8.
  - A request with both enables set is treated as a store.

## Test plan

- Reset, then store at addr 0x10 with size 8 and data 0x1122334455667788; load 0x10 with size 8 at `LAT=2` → `rsp_valid` high 2 cycles after acceptance, `read_data=0x1122334455667788`, `err=0`.
- Store 0xAB at addr 0x13 with size 1, then load 0x10 with size 4 → `read_data=0x00000000AB667788`, zero-extended.
- Store at edge N, load of the same address at edge N+1 → new data returned. `req_ready` is 0 during WAIT; `req_valid` held high there is not accepted.
- With the macro defined: load 0x11 with size 4 → `rsp_valid` one cycle later with `err=1`, `read_data=0`. Store at 0x3FC with size 8 → `err=1` and the array is unchanged.
- Without the macro: load 0x11 with size 4 → returns bytes 0x10..0x13, `err=0`.
- Assert reset during WAIT of a load → no `rsp_valid`, outputs at reset values, `req_ready=1` after release.
